cc_reorder_unit_param: RTL



---
 rtl/cc_reorder_pkg.sv | 35 +++
 rtl/cc_reorder_unit_param_if.sv | 44 ++++
 rtl/cc_reorder_unit_param_fifo.sv | 51 +++++
 rtl/cc_reorder_unit_param.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cc_reorder_pkg.sv
// Shared types and width helpers for the R-channel reorder unit.
package cc_reorder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    HIT  = 2'd2
  } state_t;

  function automatic int unsigned line_w_f(input int unsigned data_w, input int unsigned beats);
    return data_w * beats;
  endfunction

  function automatic int unsigned ofs_w_f(input int unsigned data_w, input int unsigned beats);
    return $clog2(line_w_f(data_w, beats) / 8);
  endfunction

  function automatic int unsigned hd_w_f(input int unsigned data_w, input int unsigned beats);
    return ofs_w_f(data_w, beats) + line_w_f(data_w, beats);
  endfunction

  function automatic int unsigned cnt_w_f(input int unsigned beats);
    return $clog2(beats);
  endfunction

  // Beat index a hit line starts from: the word holding the requested byte, or 0.
  function automatic int unsigned start_idx_f(input int unsigned byte_ofs,
                                              input int unsigned data_w,
                                              input int unsigned beats,
                                              input int unsigned wrap_en);
    if (wrap_en != 0) return (byte_ofs >> $clog2(data_w / 8)) % beats;
    return 0;
  endfunction

endpackage

// File: rtl/cc_reorder_unit_param_if.sv
// Memory R, INCT R and hit-flag/hit-data push signals of the reorder unit.
interface cc_reorder_unit_param_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned BEATS  = 8
);
  import cc_reorder_pkg::*;

  localparam int unsigned HD_W = hd_w_f(DATA_W, BEATS);

  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_rlast_i;
  logic              mem_rvalid_i;
  logic              mem_rready_o;
  logic              hit_flag_fifo_afull_o;
  logic              hit_flag_fifo_wren_i;
  logic              hit_flag_fifo_wdata_i;
  logic              hit_data_fifo_afull_o;
  logic              hit_data_fifo_wren_i;
  logic [HD_W-1:0]   hit_data_fifo_wdata_i;
  logic [DATA_W-1:0] inct_rdata_o;
  logic              inct_rlast_o;
  logic              inct_rvalid_o;
  logic              inct_rready_i;
  logic [1:0]        err_o;

  modport slave (
    input  mem_rdata_i, mem_rlast_i, mem_rvalid_i,
    input  hit_flag_fifo_wren_i, hit_flag_fifo_wdata_i,
    input  hit_data_fifo_wren_i, hit_data_fifo_wdata_i,
    input  inct_rready_i,
    output mem_rready_o, hit_flag_fifo_afull_o, hit_data_fifo_afull_o,
    output inct_rdata_o, inct_rlast_o, inct_rvalid_o, err_o
  );

  modport master (
    output mem_rdata_i, mem_rlast_i, mem_rvalid_i,
    output hit_flag_fifo_wren_i, hit_flag_fifo_wdata_i,
    output hit_data_fifo_wren_i, hit_data_fifo_wdata_i,
    output inct_rready_i,
    input  mem_rready_o, hit_flag_fifo_afull_o, hit_data_fifo_afull_o,
    input  inct_rdata_o, inct_rlast_o, inct_rvalid_o, err_o
  );

endinterface

// File: rtl/cc_reorder_unit_param_fifo.sv
// CC FIFO: synchronous show-ahead FIFO; pushes to a full FIFO are dropped and flagged.
module cc_reorder_unit_param_fifo #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AFULL = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wren,
  input  logic [W-1:0] wdata,
  input  logic         rden,
  output logic [W-1:0] rdata_c,
  output logic         empty_c,
  output logic         afull_c,
  output logic         ovf_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign pop_ok  = rden && !empty_c;
  // A pop in the same cycle frees the slot, so push+pop on full is legal.
  assign push_ok = wren && (!full || pop_ok);
  assign ovf_c   = wren && !push_ok;
  assign afull_c = ((CNT_W'(DEPTH) - count_q) <= CNT_W'(AFULL));
  assign rdata_c = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
      if (pop_ok)  rptr_q <= (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/cc_reorder_unit_param.sv
// R-channel reorder unit: merges memory miss bursts and buffered hit lines
// back to INCT in request order, as dictated by the hit-flag stream.
module cc_reorder_unit_param
  import cc_reorder_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned BEATS       = 8,
  parameter int unsigned WRAP_EN     = 1,
  parameter int unsigned FLAG_DEPTH  = 4,
  parameter int unsigned FLAG_AFULL  = 2,
  parameter int unsigned HDATA_DEPTH = 2,
  parameter int unsigned HDATA_AFULL = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  cc_reorder_unit_param_if.slave bus
);

  localparam int unsigned LINE_W = line_w_f(DATA_W, BEATS);
  localparam int unsigned OFS_W  = ofs_w_f(DATA_W, BEATS);
  localparam int unsigned HD_W   = hd_w_f(DATA_W, BEATS);
  localparam int unsigned CNT_W  = cnt_w_f(BEATS);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, start_q, idx;
  logic [LINE_W-1:0]   line_q;
  logic [1:0]          err_q;
  logic                flag_head, flag_empty, flag_ovf, flag_pop;
  logic [HD_W-1:0]     hd_head;
  logic                hd_empty, hd_ovf, hd_pop;
  logic                load, done, err0_set;
  logic                rvalid_c, rlast_c, rready_c;
  logic [DATA_W-1:0]   rdata_c;

  cc_reorder_unit_param_fifo #(.W(1), .DEPTH(FLAG_DEPTH), .AFULL(FLAG_AFULL)) u_flag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wren    (bus.hit_flag_fifo_wren_i),
    .wdata   (bus.hit_flag_fifo_wdata_i),
    .rden    (flag_pop),
    .rdata_c (flag_head),
    .empty_c (flag_empty),
    .afull_c (bus.hit_flag_fifo_afull_o),
    .ovf_c   (flag_ovf)
  );

  cc_reorder_unit_param_fifo #(.W(HD_W), .DEPTH(HDATA_DEPTH), .AFULL(HDATA_AFULL)) u_hdata_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wren    (bus.hit_data_fifo_wren_i),
    .wdata   (bus.hit_data_fifo_wdata_i),
    .rden    (hd_pop),
    .rdata_c (hd_head),
    .empty_c (hd_empty),
    .afull_c (bus.hit_data_fifo_afull_o),
    .ovf_c   (hd_ovf)
  );

  // Natural CNT_W-bit wrap gives the critical-word-first order.
  assign idx = start_q + cnt_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flag_pop = 1'b0;
    hd_pop   = 1'b0;
    load     = 1'b0;
    done     = 1'b0;
    err0_set = 1'b0;
    rvalid_c = 1'b0;
    rlast_c  = 1'b0;
    rready_c = 1'b0;
    rdata_c  = '0;
    case (state_q)
      MISS: begin
        rvalid_c = bus.mem_rvalid_i;
        rdata_c  = bus.mem_rdata_i;
        rlast_c  = bus.mem_rlast_i;
        rready_c = bus.inct_rready_i;
        if (bus.mem_rvalid_i && bus.inct_rready_i) begin
          cnt_d    = cnt_q + CNT_W'(1);
          err0_set = (bus.mem_rlast_i != (cnt_q == CNT_W'(BEATS - 1)));
          done     = bus.mem_rlast_i;
        end
      end
      HIT: begin
        rvalid_c = 1'b1;
        rdata_c  = line_q[idx*DATA_W +: DATA_W];
        rlast_c  = (cnt_q == CNT_W'(BEATS - 1));
        if (bus.inct_rready_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          done  = rlast_c;
        end
      end
      default: ;
    endcase
    // Dispatch from IDLE, or straight out of a final beat for zero-bubble chaining.
    if (state_q == IDLE || done) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (!flag_empty) begin
        if (!flag_head) begin
          flag_pop = 1'b1;
          state_d  = MISS;
        end else if (!hd_empty) begin
          flag_pop = 1'b1;
          hd_pop   = 1'b1;
          load     = 1'b1;
          state_d  = HIT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) start_q <= CNT_W'(start_idx_f(32'(hd_head[HD_W-1 -: OFS_W]), DATA_W, BEATS, WRAP_EN));
      err_q <= err_q | {flag_ovf || hd_ovf, err0_set};
    end
  end

  always_ff @(posedge clk) begin
    if (load) line_q <= hd_head[LINE_W-1:0];
  end

  assign bus.inct_rvalid_o = rvalid_c;
  assign bus.inct_rdata_o  = rdata_c;
  assign bus.inct_rlast_o  = rlast_c;
  assign bus.mem_rready_o  = rready_c;
  assign bus.err_o         = err_q;

endmodule
